// File: rtl/parallel_to_serial_if.sv
// Load handshake between the parallel word source (master) and the frame transmitter (slave).
interface parallel_to_serial_if;
  logic [7:0] parallelIn;
  logic       loadValid;
  logic       loadReady;

  // A word moves on any posedge where loadValid && loadReady; while valid and not ready the source holds parallelIn.
  modport master (output parallelIn, output loadValid, input loadReady);
  modport slave  (input parallelIn, input loadValid, output loadReady);
endinterface

// File: rtl/parallel_to_serial.sv
// 11-bit LSB-first frame transmitter: start, D0..D7, bit 9, stop.
// PARALLEL_TO_SERIAL_PARITY_EN makes bit 9 even parity; otherwise bit 9 is a second stop bit.
module parallel_to_serial #(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   parallel_to_serial_if.slave  load,
   output logic                 serialOut,
   output logic                 busy,
   output logic                 frameDone,
   output logic [0:0]           stateDbg
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]    LAST_BIT = 4'd10;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;

   logic [0:0]    state, nextState;
   logic [7:0]    dataReg, nextData;
   logic [3:0]    bitIdx, nextIdx;
   logic [CW-1:0] bitCnt, nextCnt;
   logic          lastCycle;
   logic          accept;

   function automatic logic frameBit(input logic [7:0] d, input logic [3:0] idx);
      logic b;
      case (idx)
         4'd0:                                  b = 1'b0;
         4'd1, 4'd2, 4'd3, 4'd4,
         4'd5, 4'd6, 4'd7, 4'd8:                b = d[idx[2:0] - 3'd1];
`ifdef PARALLEL_TO_SERIAL_PARITY_EN
         4'd9:                                  b = ^d;
`else
         4'd9:                                  b = 1'b1;
`endif
         default:                               b = 1'b1;
      endcase
      return b;
   endfunction

   // Ready in idle and in the very last frame cycle, which is what allows gapless frames.
   assign lastCycle      = (state == SEND) && (bitIdx == LAST_BIT) && (bitCnt == CNT_MAX);
   assign load.loadReady = (state == IDLE) || lastCycle;
   assign accept         = load.loadValid && load.loadReady;
   assign stateDbg       = state;

   always_comb begin
      nextState = state;
      nextData  = dataReg;
      nextIdx   = bitIdx;
      nextCnt   = bitCnt;
      if (accept) begin
         nextState = SEND;
         nextData  = load.parallelIn;
         nextIdx   = 4'd0;
         nextCnt   = '0;
      end else if (state == SEND) begin
         if (bitCnt == CNT_MAX) begin
            nextCnt = '0;
            if (bitIdx == LAST_BIT) begin
               nextState = IDLE;
               nextIdx   = 4'd0;
            end else begin
               nextIdx = bitIdx + 4'd1;
            end
         end else begin
            nextCnt = bitCnt + CW'(1);
         end
      end
   end

   // Outputs are registered from the next-state values so they line up with the bit being held.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         dataReg   <= 8'h00;
         bitIdx    <= 4'd0;
         bitCnt    <= '0;
         serialOut <= 1'b1;
         busy      <= 1'b0;
         frameDone <= 1'b0;
      end else begin
         state     <= nextState;
         dataReg   <= nextData;
         bitIdx    <= nextIdx;
         bitCnt    <= nextCnt;
         serialOut <= (nextState == SEND) ? frameBit(nextData, nextIdx) : 1'b1;
         busy      <= (nextState == SEND);
         frameDone <= (nextState == SEND) && (nextIdx == LAST_BIT) && (nextCnt == CNT_MAX);
      end
   end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Directed bench for parallel_to_serial at CLKS_PER_BIT 1 and 4; follows PARALLEL_TO_SERIAL_PARITY_EN for bit 9.
module tb_parallel_to_serial;

   logic       clk;
   logic       reset;
   logic       serialOut1, busy1, frameDone1;
   logic       serialOut4, busy4, frameDone4;
   logic [0:0] stateDbg1, stateDbg4;
   int         errors;
   int         checks;

   parallel_to_serial_if if1 ();
   parallel_to_serial_if if4 ();

   parallel_to_serial #(.CLKS_PER_BIT(1)) dut1 (
      .clk(clk), .reset(reset), .load(if1),
      .serialOut(serialOut1), .busy(busy1), .frameDone(frameDone1), .stateDbg(stateDbg1)
   );

   parallel_to_serial #(.CLKS_PER_BIT(4)) dut4 (
      .clk(clk), .reset(reset), .load(if4),
      .serialOut(serialOut4), .busy(busy4), .frameDone(frameDone4), .stateDbg(stateDbg4)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected 11-bit frame, bit k is the value on the line during frame bit k.
   function automatic logic [10:0] frame_of(input logic [7:0] d);
      logic p;
`ifdef PARALLEL_TO_SERIAL_PARITY_EN
      p = ^d;
`else
      p = 1'b1;
`endif
      return {1'b1, p, d, 1'b0};
   endfunction

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (serialOut1 !== 1'b1 || busy1 !== 1'b0 || frameDone1 !== 1'b0 || if1.loadReady !== 1'b1 || stateDbg1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_dut1: serialOut=%b busy=%b frameDone=%b loadReady=%b state=%b, required 1 0 0 1 0",
                  serialOut1, busy1, frameDone1, if1.loadReady, stateDbg1);
      end
      checks++;
      if (serialOut4 !== 1'b1 || busy4 !== 1'b0 || frameDone4 !== 1'b0 || if4.loadReady !== 1'b1 || stateDbg4 !== 1'b0) begin
         errors++;
         $display("FAIL reset_dut4: serialOut=%b busy=%b frameDone=%b loadReady=%b state=%b, required 1 0 0 1 0",
                  serialOut4, busy4, frameDone4, if4.loadReady, stateDbg4);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_single(input logic [7:0] d);
      logic [10:0] exp;
      exp = frame_of(d);
      @(negedge clk);
      checks++;
      if (if1.loadReady !== 1'b1) begin
         errors++;
         $display("FAIL single_ready_%h: loadReady=%b, required 1", d, if1.loadReady);
      end
      if1.loadValid  = 1'b1;
      if1.parallelIn = d;
      for (int k = 0; k <= 10; k++) begin
         @(negedge clk);
         if (k == 0) begin
            if1.loadValid  = 1'b0;
            if1.parallelIn = ~d;
         end
         checks++;
         if (serialOut1 !== exp[k] || frameDone1 !== (k == 10) || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL single_%h_bit%0d: serialOut=%b frameDone=%b busy=%b, required %b %b 1",
                     d, k, serialOut1, frameDone1, busy1, exp[k], (k == 10));
         end
      end
      @(negedge clk);
      checks++;
      if (busy1 !== 1'b0 || serialOut1 !== 1'b1 || frameDone1 !== 1'b0) begin
         errors++;
         $display("FAIL single_%h_idle: busy=%b serialOut=%b frameDone=%b, required 0 1 0",
                  d, busy1, serialOut1, frameDone1);
      end
   endtask

   task automatic test_back_to_back();
      logic [10:0] exp_a;
      logic [10:0] exp_b;
      exp_a = frame_of(8'h01);
      exp_b = frame_of(8'hFF);
      @(negedge clk);
      if1.loadValid  = 1'b1;
      if1.parallelIn = 8'h01;
      for (int k = 0; k <= 10; k++) begin
         @(negedge clk);
         if (k == 0) if1.parallelIn = 8'hFF;
         checks++;
         if (serialOut1 !== exp_a[k] || if1.loadReady !== (k == 10)) begin
            errors++;
            $display("FAIL b2b_first_bit%0d: serialOut=%b loadReady=%b, required %b %b",
                     k, serialOut1, if1.loadReady, exp_a[k], (k == 10));
         end
      end
      for (int k = 0; k <= 10; k++) begin
         @(negedge clk);
         if (k == 0) if1.loadValid = 1'b0;
         checks++;
         if (serialOut1 !== exp_b[k] || busy1 !== 1'b1 || frameDone1 !== (k == 10)) begin
            errors++;
            $display("FAIL b2b_second_bit%0d: serialOut=%b busy=%b frameDone=%b, required %b 1 %b",
                     k, serialOut1, busy1, frameDone1, exp_b[k], (k == 10));
         end
      end
      @(negedge clk);
      checks++;
      if (busy1 !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle: busy=%b, required 0", busy1);
      end
   endtask

   task automatic test_ignored_load();
      logic [10:0] exp;
      exp = frame_of(8'h96);
      @(negedge clk);
      if1.loadValid  = 1'b1;
      if1.parallelIn = 8'h96;
      for (int k = 0; k <= 10; k++) begin
         @(negedge clk);
         if1.loadValid = 1'b0;
         if (k == 4) begin
            if1.loadValid  = 1'b1;
            if1.parallelIn = 8'h3C;
            checks++;
            if (if1.loadReady !== 1'b0) begin
               errors++;
               $display("FAIL ignored_ready: loadReady=%b, required 0", if1.loadReady);
            end
         end
         checks++;
         if (serialOut1 !== exp[k]) begin
            errors++;
            $display("FAIL ignored_bit%0d: serialOut=%b, required %b", k, serialOut1, exp[k]);
         end
      end
      @(negedge clk);
      checks++;
      if (busy1 !== 1'b0 || serialOut1 !== 1'b1) begin
         errors++;
         $display("FAIL ignored_idle: busy=%b serialOut=%b, required 0 1", busy1, serialOut1);
      end
   endtask

   task automatic test_slow_rate();
      logic [10:0] exp;
      exp = frame_of(8'h80);
      @(negedge clk);
      if4.loadValid  = 1'b1;
      if4.parallelIn = 8'h80;
      for (int j = 0; j < 44; j++) begin
         @(negedge clk);
         if (j == 0) if4.loadValid = 1'b0;
         checks++;
         if (serialOut4 !== exp[j / 4] || busy4 !== 1'b1 || frameDone4 !== (j == 43)) begin
            errors++;
            $display("FAIL slow_cycle%0d: serialOut=%b busy=%b frameDone=%b, required %b 1 %b",
                     j, serialOut4, busy4, frameDone4, exp[j / 4], (j == 43));
         end
      end
      @(negedge clk);
      checks++;
      if (busy4 !== 1'b0 || serialOut4 !== 1'b1) begin
         errors++;
         $display("FAIL slow_idle: busy=%b serialOut=%b, required 0 1", busy4, serialOut4);
      end
   endtask

   task automatic test_reset_mid_frame();
      @(negedge clk);
      if1.loadValid  = 1'b1;
      if1.parallelIn = 8'h00;
      @(negedge clk);
      if1.loadValid = 1'b0;
      repeat (6) @(negedge clk);
      checks++;
      if (serialOut1 !== 1'b0 || busy1 !== 1'b1) begin
         errors++;
         $display("FAIL midreset_bit6: serialOut=%b busy=%b, required 0 1", serialOut1, busy1);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (serialOut1 !== 1'b1 || busy1 !== 1'b0 || frameDone1 !== 1'b0 || if1.loadReady !== 1'b1) begin
         errors++;
         $display("FAIL midreset_async: serialOut=%b busy=%b frameDone=%b loadReady=%b, required 1 0 0 1",
                  serialOut1, busy1, frameDone1, if1.loadReady);
      end
      // A load presented during reset must not be captured.
      if1.loadValid  = 1'b1;
      if1.parallelIn = 8'h77;
      @(negedge clk);
      checks++;
      if (busy1 !== 1'b0 || serialOut1 !== 1'b1) begin
         errors++;
         $display("FAIL midreset_load_blocked: busy=%b serialOut=%b, required 0 1", busy1, serialOut1);
      end
      if1.loadValid = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (busy1 !== 1'b0 || stateDbg1 !== 1'b0) begin
         errors++;
         $display("FAIL midreset_after_release: busy=%b state=%b, required 0 0", busy1, stateDbg1);
      end
      test_single(8'h55);
   endtask

   initial begin
      errors         = 0;
      checks         = 0;
      reset          = 1'b1;
      if1.loadValid  = 1'b0;
      if1.parallelIn = 8'h00;
      if4.loadValid  = 1'b0;
      if4.parallelIn = 8'h00;
      test_reset();
      test_single(8'hA5);
      test_back_to_back();
      test_ignored_load();
      test_slow_rate();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
